// File: rtl/bram_row_loader.sv
// Raster-to-row-bank write engine: streams 8-bit pixels into K row banks
// (column = address), gated by reader credits, with window/row/frame pulses.
module bram_row_loader #(
    parameter int K      = 9,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              rd_row_done,
    output logic [K-1:0]      wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              win_start,
    output logic              row_ready,
    output logic              frame_done,
    output logic              busy,
    output logic              ovf_err
);

    localparam int BANK_W = (K > 1) ? $clog2(K) : 1;
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int FREE_W = $clog2(K + 1);

    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(K - 1);
    localparam logic [ROW_W-1:0]  ROW_WIN   = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [FREE_W-1:0] FREE_K    = FREE_W'(K);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] col_reg;
    logic [BANK_W-1:0] bank_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [FREE_W-1:0] free_reg;
    logic [FREE_W-1:0] free_next;
    logic              ovf_set;
    logic              accept;
    logic              row_end;
    logic [K-1:0]      bank_hot;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_hot
            assign bank_hot[gi] = (bank_reg == BANK_W'(gi));
        end
    endgenerate

    assign s_ready = ((state_reg == FILL) || (state_reg == STREAM)) && (free_reg != '0);
    assign accept  = s_valid && s_ready;
    assign row_end = accept && (col_reg == COL_LAST);

    // A credit arriving with a row completion cancels out; a credit with
    // every bank already free is a reader protocol error.
    always_comb begin
        free_next = free_reg;
        ovf_set   = 1'b0;
        if (rd_row_done && !row_end) begin
            if (free_reg == FREE_K) begin
                ovf_set = 1'b1;
            end else begin
                free_next = free_reg + 1'b1;
            end
        end else if (!rd_row_done && row_end) begin
            free_next = free_reg - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            bank_reg   <= '0;
            row_reg    <= '0;
            free_reg   <= FREE_K;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            win_start  <= 1'b0;
            row_ready  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            wr_en      <= '0;
            win_start  <= 1'b0;
            row_ready  <= 1'b0;
            frame_done <= 1'b0;
            free_reg   <= free_next;
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end

            if (accept) begin
                wr_en   <= bank_hot;
                wr_addr <= col_reg;
                wr_data <= s_data;
                if (row_end) begin
                    col_reg  <= '0;
                    bank_reg <= (bank_reg == BANK_LAST) ? '0 : bank_reg + 1'b1;
                    row_reg  <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= FILL;
                        col_reg   <= '0;
                        bank_reg  <= '0;
                        row_reg   <= '0;
                        free_reg  <= FREE_K;
                        busy      <= 1'b1;
                    end
                end
                FILL: begin
                    if (row_end && (row_reg == ROW_WIN)) begin
                        win_start <= 1'b1;
                        state_reg <= (row_reg == ROW_LAST) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (row_end) begin
                        row_ready <= 1'b1;
                        if (row_reg == ROW_LAST) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_row_loader.sv
// Scoreboard bench for bram_row_loader: the driver queues expected writes,
// a negedge monitor pops and compares every wr_en cycle.
module tb_bram_row_loader;

    localparam int K      = 9;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 12;
    localparam int ADDR_W = 3;

    logic              CLK = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              rd_row_done = 1'b0;
    logic              s_ready;
    logic [K-1:0]      wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              win_start;
    logic              row_ready;
    logic              frame_done;
    logic              busy;
    logic              ovf_err;

    bram_row_loader #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .rd_row_done(rd_row_done), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .win_start(win_start),
        .row_ready(row_ready), .frame_done(frame_done), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [K-1:0]      en;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              ws;
        logic              rr;
    } wr_t;

    wr_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  wr_count   = 0;
    int  ws_count   = 0;
    int  rr_count   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {6'd0, s_ready, wr_en, wr_addr, wr_data, win_start, row_ready,
                     frame_done, busy, ovf_err}, 32'd0);
    endtask

    // Present one beat, wait (bounded) for acceptance, queue its expected write.
    task automatic beat(input logic [7:0] d, input int bank, input int addr,
                        input bit ws, input bit rr, input bit credit);
        int           waitc;
        wr_t          e;
        logic [K-1:0] one;
        waitc   = 0;
        one     = 1;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && waitc < 200) begin
            @(negedge CLK);
            waitc++;
        end
        if (!s_ready) begin
            compared++;
            mismatched++;
            $display("FAIL beat_timeout: data=%0d s_ready=0 after %0d cycles, required 1", d, waitc);
        end else begin
            e.en   = one << bank;
            e.addr = ADDR_W'(addr);
            e.data = d;
            e.ws   = ws;
            e.rr   = rr;
            exp_q.push_back(e);
            rd_row_done = credit;
            @(negedge CLK);
            rd_row_done = 1'b0;
        end
    endtask

    initial begin : monitor
        wr_t e;
        wr_t a;
        forever begin
            @(negedge CLK);
            if (wr_en != '0) begin
                wr_count++;
                if (win_start) ws_count++;
                if (row_ready) rr_count++;
                a = '{en: wr_en, addr: wr_addr, data: wr_data, ws: win_start, rr: row_ready};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_write: en=%b addr=%0d data=%0d, required no write",
                             wr_en, wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        mismatched++;
                        $display("FAIL write: en=%b addr=%0d data=%0d ws=%0b rr=%0b, required en=%b addr=%0d data=%0d ws=%0b rr=%0b",
                                 a.en, a.addr, a.data, a.ws, a.rr, e.en, e.addr, e.data, e.ws, e.rr);
                    end
                end
            end else if (win_start || row_ready) begin
                compared++;
                mismatched++;
                $display("FAIL stray_pulse: win_start=%0b row_ready=%0b with no write, required 0",
                         win_start, row_ready);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted between clock edges must clear outputs immediately
        #12 rst = 1'b1;
        #1 check_reset_outputs("reset_outputs");
        @(negedge CLK);
        rst = 1'b0;

        // Fill: 9 rows of 8 beats, data = beat index
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 72; i++) begin
            beat(8'(i), i / IMG_W, i % IMG_W, (i == 71), 1'b0, 1'b0);
        end
        check("fill_sready_low", s_ready, 0);

        // Backpressure: all banks used, valid held high
        s_data = 8'hEE;
        begin
            bit seen;
            seen = 1'b0;
            repeat (10) begin
                @(negedge CLK);
                if (s_ready) seen = 1'b1;
            end
            #1;
            check("bp_sready_held_low", seen, 0);
            check("bp_no_writes", wr_count, 72);
            check("win_start_count", ws_count, 1);
        end
        rd_row_done = 1'b1;
        @(negedge CLK);
        rd_row_done = 1'b0;
        check("credit_sready_rise", s_ready, 1);
        for (int i = 0; i < 8; i++) begin
            beat(8'(72 + i), 0, i, 1'b0, (i == 7), 1'b0);
        end
        #1;
        check("row9_row_ready_count", rr_count, 1);
        check("row9_sready_low", s_ready, 0);

        // Simultaneous credit on the last beat of row 10 (free == 1)
        rd_row_done = 1'b1;
        @(negedge CLK);
        rd_row_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(8'(80 + i), 1, i, 1'b0, (i == 7), (i == 7));
        end
        check("simul_credit_sready", s_ready, 1);

        // Final row, then frame_done one cycle after the last write
        for (int i = 0; i < 8; i++) begin
            beat(8'(88 + i), 2, i, 1'b0, (i == 7), 1'b0);
        end
        s_data = 8'hEE;
        check("end_sready_drop", s_ready, 0);
        check("end_frame_done_early", frame_done, 0);
        @(negedge CLK);
        check("frame_done_pulse", frame_done, 1);
        check("busy_cleared", busy, 0);
        @(negedge CLK);
        check("frame_done_one_cycle", frame_done, 0);
        repeat (4) @(negedge CLK);
        #1;
        check("frame_write_count", wr_count, 96);
        check("frame_row_ready_count", rr_count, 3);
        check("frame_ovf_clear", ovf_err, 0);
        check("frame_queue_drained", exp_q.size(), 0);
        s_valid = 1'b0;

        // Abort a frame after 3 beats, then restart from bank 0 addr 0
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(8'(8'hA0 + i), 0, i, 1'b0, 1'b0, 1'b0);
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort_reset_outputs");
        @(negedge CLK); rst = 1'b0;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        beat(8'h55, 0, 0, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        #1;
        check("restart_write_count", wr_count, 100);
        check("restart_queue_drained", exp_q.size(), 0);

        // Credit while idle with every bank free sets the sticky error
        #1 rst = 1'b1;
        @(negedge CLK); rst = 1'b0;
        rd_row_done = 1'b1;
        @(negedge CLK); rd_row_done = 1'b0;
        check("ovf_set", ovf_err, 1);
        repeat (5) @(negedge CLK);
        check("ovf_sticky", ovf_err, 1);
        #2 rst = 1'b1;
        #1 check("ovf_cleared_by_reset", ovf_err, 0);
        @(negedge CLK); rst = 1'b0;
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
